// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Latency: none, since this file holds only constants and types.
// Backpressure: none; stalling is handled by the top-level busy/start flags.
package md_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_run_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide ops.
  function automatic logic md_is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero flag.
// Latency: zero cycles; the result is captured by the parent on the start edge.
// Backpressure: none; the parent decides when the result is used.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div_zero
);

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_div;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Sign-magnitude arithmetic: unsigned core, signs restored afterwards.
  // MIN_INT magnitude is 2^(WIDTH-1) as unsigned, so MIN_INT/-1 yields MIN_INT, rem 0.
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    // Guard the divider so a zero divisor never reaches it; result is discarded anyway.
    b_div     = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    prod      = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    quot      = a_mag / b_div;
    rem       = a_mag % b_div;
    if (a_neg ^ b_neg) begin
      prod = ~prod + 1'b1;
      quot = ~quot + 1'b1;
    end
    if (a_neg) begin
      rem = ~rem + 1'b1;
    end

    hi       = '0;
    lo       = '0;
    div_zero = 1'b0;
    if (op == MD_MULT || op == MD_MULTU) begin
      {hi, lo} = prod;
    end else if (md_is_div_op(op)) begin
      hi       = rem;
      lo       = quot;
      div_zero = (b == '0);
    end
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit with architectural HI/LO and MFHI/MFLO/MTHI/MTLO.
// Latency: MULT_CYCLES or DIV_CYCLES from the start edge to HI/LO update; MT* one edge.
// Backpressure: E_MD_busy/E_MD_start tell the stall unit to hold E; ops during busy are ignored.
module e_muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               E_MD_en,
  input  logic [MD_OP_W-1:0] E_MD_op,
  input  logic [WIDTH-1:0]   E_A,
  input  logic [WIDTH-1:0]   E_B,
  output logic               E_MD_busy,
  output logic               E_MD_start,
  output logic [WIDTH-1:0]   E_HI,
  output logic [WIDTH-1:0]   E_LO,
  output logic [WIDTH-1:0]   E_MD_out
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_ok;

  logic [WIDTH-1:0] ar_hi;
  logic [WIDTH-1:0] ar_lo;
  logic             ar_div_zero;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op       (E_MD_op),
    .a        (E_A),
    .b        (E_B),
    .hi       (ar_hi),
    .lo       (ar_lo),
    .div_zero (ar_div_zero)
  );

  // A new mult/div is accepted only when the unit is idle.
  always_comb begin
    E_MD_start = E_MD_en & md_is_run_op(E_MD_op) & ~E_MD_busy;
  end

  // Latency counter, result capture on start, HI/LO commit on the final busy edge, MT* writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      E_MD_busy <= 1'b0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_ok   <= 1'b0;
      E_HI      <= '0;
      E_LO      <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (E_MD_start) begin
            state     <= MD_RUN;
            E_MD_busy <= 1'b1;
            cnt       <= md_is_div_op(E_MD_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_hi   <= ar_hi;
            pend_lo   <= ar_lo;
            // A zero divisor still occupies the unit but must not touch HI/LO.
            pend_ok   <= ~ar_div_zero;
          end else if (E_MD_en && E_MD_op == MD_MTHI) begin
            E_HI <= E_A;
          end else if (E_MD_en && E_MD_op == MD_MTLO) begin
            E_LO <= E_A;
          end
        end
        MD_RUN: begin
          if (cnt == CNT_W'(1)) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            E_MD_busy <= 1'b0;
            if (pend_ok) begin
              E_HI <= pend_hi;
              E_LO <= pend_lo;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= MD_IDLE;
          cnt       <= '0;
          E_MD_busy <= 1'b0;
        end
      endcase
    end
  end

  // Move-from read mux; while busy it returns the old HI/LO.
  always_comb begin
    E_MD_out = '0;
    if (E_MD_op == MD_MFHI) begin
      E_MD_out = E_HI;
    end else if (E_MD_op == MD_MFLO) begin
      E_MD_out = E_LO;
    end
  end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Randomized and directed bench for e_muldiv_unit against a cycle-level reference model.
// Latency: model tracks remaining busy cycles per started op.
// Backpressure: ops issued while busy are expected to be ignored (MF* reads old HI/LO).
module tb_e_muldiv_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               E_MD_en;
  logic [MD_OP_W-1:0] E_MD_op;
  logic [W-1:0]       E_A;
  logic [W-1:0]       E_B;
  logic               E_MD_busy;
  logic               E_MD_start;
  logic [W-1:0]       E_HI;
  logic [W-1:0]       E_LO;
  logic [W-1:0]       E_MD_out;

  e_muldiv_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_MD_en    (E_MD_en),
    .E_MD_op    (E_MD_op),
    .E_A        (E_A),
    .E_B        (E_B),
    .E_MD_busy  (E_MD_busy),
    .E_MD_start (E_MD_start),
    .E_HI       (E_HI),
    .E_LO       (E_LO),
    .E_MD_out   (E_MD_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: architectural HI/LO plus the in-flight result and its remaining cycles.
  logic [W-1:0] m_hi, m_lo, m_ph, m_pl;
  logic         m_pok;
  int           m_left;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of a mult/div computed with 64-bit integer arithmetic.
  task automatic ref_compute(input logic [MD_OP_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] rh, output logic [W-1:0] rl, output logic ok);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ok = 1'b1;
    rh = '0;
    rl = '0;
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
      MD_DIV: begin
        if (b == 0) ok = 1'b0;
        else begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); rl = p[31:0];
          p = 64'(r); rh = p[31:0];
        end
      end
      MD_DIVU: begin
        if (b == 0) ok = 1'b0;
        else begin
          p = {32'b0, a} / {32'b0, b}; rl = p[31:0];
          p = {32'b0, a} % {32'b0, b}; rh = p[31:0];
        end
      end
      default: ok = 1'b0;
    endcase
  endtask

  task automatic model_step(input logic en, input logic [MD_OP_W-1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic rst);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_pok = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin
        m_hi = m_ph; m_lo = m_pl;
      end
    end else if (en && op >= MD_MULT && op <= MD_DIVU) begin
      ref_compute(op, a, b, m_ph, m_pl, m_pok);
      m_left = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
    end else if (en && op == MD_MTHI) begin
      m_hi = a;
    end else if (en && op == MD_MTLO) begin
      m_lo = a;
    end
  endtask

  // Apply one cycle of inputs, compare all outputs before the edge, then advance the model.
  task automatic cycle(input logic en, input logic [MD_OP_W-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic rst);
    logic [W-1:0] exp_out;
    reset = rst; E_MD_en = en; E_MD_op = op; E_A = a; E_B = b;
    #1;
    exp_out = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : '0;
    chk("busy",  64'(E_MD_busy),  64'(m_left != 0));
    chk("start", 64'(E_MD_start), 64'(en && op >= MD_MULT && op <= MD_DIVU && m_left == 0));
    chk("hi",    64'(E_HI),       64'(m_hi));
    chk("lo",    64'(E_LO),       64'(m_lo));
    chk("out",   64'(E_MD_out),   64'(exp_out));
    @(posedge clk);
    model_step(en, op, a, b, rst);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, MD_NONE, $urandom, $urandom, 1'b0);
  endtask

  // Run idle cycles until busy drops; returns busy cycles seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (E_MD_busy && n < 100) begin
      idle();
      n++;
    end
    if (n >= 100) chk("busy_timeout", 64'(E_MD_busy), 64'd0);
  endtask

  // Peek a move-from read in the current cycle without advancing time past an edge.
  task automatic peek(input logic [MD_OP_W-1:0] op, input string tag, input logic [W-1:0] exp);
    reset = 1'b0; E_MD_en = 1'b1; E_MD_op = op;
    #1;
    chk(tag, 64'(E_MD_out), 64'(exp));
  endtask

  initial begin
    int n;
    logic [W-1:0] sh, sl;
    logic [MD_OP_W-1:0] op;
    logic [W-1:0] a, b;
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_pok = 1'b0; m_left = 0;
    reset = 1'b1; E_MD_en = 1'b0; E_MD_op = MD_NONE; E_A = '0; E_B = '0;
    @(posedge clk); #1;
    cycle(1'b0, MD_NONE, 0, 0, 1'b1);
    chk("rst_busy", 64'(E_MD_busy), 64'd0);
    chk("rst_hi",   64'(E_HI),      64'd0);
    chk("rst_lo",   64'(E_LO),      64'd0);

    // MULT -3 * 7
    cycle(1'b1, MD_MULT, -32'sd3, 32'sd7, 1'b0);
    wait_done(n);
    chk("mult_len", 64'(n), 64'(MC));
    chk("mult_hi", 64'(E_HI), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(E_LO), 64'hFFFF_FFEB);
    peek(MD_MFLO, "mflo_after_mult", 32'hFFFF_FFEB);

    // MULTU FFFFFFFF * 2
    cycle(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(n);
    chk("multu_hi", 64'(E_HI), 64'h1);
    chk("multu_lo", 64'(E_LO), 64'hFFFF_FFFE);

    // DIV -7 / 2
    cycle(1'b1, MD_DIV, -32'sd7, 32'sd2, 1'b0);
    wait_done(n);
    chk("div_len", 64'(n), 64'(DC));
    chk("div_lo", 64'(E_LO), 64'hFFFF_FFFD);
    chk("div_hi", 64'(E_HI), 64'hFFFF_FFFF);

    // DIV MIN_INT / -1
    cycle(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(n);
    chk("divmin_lo", 64'(E_LO), 64'h8000_0000);
    chk("divmin_hi", 64'(E_HI), 64'h0);

    // DIVU by zero leaves HI/LO alone but still runs the full latency
    sh = E_HI; sl = E_LO;
    cycle(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0);
    wait_done(n);
    chk("divz_len", 64'(n), 64'(DC));
    chk("divz_hi", 64'(E_HI), 64'(sh));
    chk("divz_lo", 64'(E_LO), 64'(sl));

    // MTHI then MFHI
    cycle(1'b1, MD_MTHI, 32'h1234, 32'd0, 1'b0);
    peek(MD_MFHI, "mfhi_after_mthi", 32'h1234);

    // MTLO while busy is ignored
    cycle(1'b1, MD_MULT, 32'd5, 32'd6, 1'b0);
    cycle(1'b1, MD_MTLO, 32'hDEAD, 32'd0, 1'b0);
    wait_done(n);
    chk("mtlo_busy_lo", 64'(E_LO), 64'd30);

    // Reset in the middle of a DIV aborts with no commit
    cycle(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    idle(); idle();
    cycle(1'b0, MD_NONE, 0, 0, 1'b1);
    for (int i = 0; i < 14; i++) idle();
    chk("abort_busy", 64'(E_MD_busy), 64'd0);
    chk("abort_hi", 64'(E_HI), 64'd0);
    chk("abort_lo", 64'(E_LO), 64'd0);

    // Second start during a MULT is ignored; back-to-back start is accepted
    cycle(1'b1, MD_MULT, 32'd4, 32'd5, 1'b0);
    idle();
    cycle(1'b1, MD_MULT, 32'd9, 32'd9, 1'b0);
    wait_done(n);
    chk("restart_lo", 64'(E_LO), 64'd20);
    cycle(1'b1, MD_MULTU, 32'd3, 32'd3, 1'b0);
    chk("b2b_busy", 64'(E_MD_busy), 64'd1);
    wait_done(n);
    chk("b2b_lo", 64'(E_LO), 64'd9);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      op = MD_OP_W'($urandom_range(0, 8));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      cycle($urandom_range(0, 7) != 0, op, a, b, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
